// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array datapath: widths, int8 bounds,
// output modes and frame lengths used by the result drain stage.
package tpu_pkg;

    localparam int unsigned ACC_W          = 16;
    localparam int unsigned N_OUT          = 4;
    localparam int          INT8_MAX       = 127;
    localparam int          INT8_MIN       = -128;
    localparam int unsigned FRAME_LEN_RAW  = 8;
    localparam int unsigned FRAME_LEN_INT8 = 4;

    typedef enum logic [1:0] {
        MODE_RAW   = 2'b00,
        MODE_SAT8  = 2'b01,
        MODE_RELU8 = 2'b10,
        MODE_RSVD  = 2'b11
    } out_mode_t;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } stream_state_t;

    function automatic logic is_int8_mode(input out_mode_t m);
        return (m == MODE_SAT8) || (m == MODE_RELU8);
    endfunction

    // Reserved mode falls through to the raw frame length.
    function automatic logic [2:0] last_index(input out_mode_t m);
        return is_int8_mode(m) ? 3'(FRAME_LEN_INT8 - 1) : 3'(FRAME_LEN_RAW - 1);
    endfunction

endpackage

// File: rtl/int8_saturator.sv
// Signed clamp of an accumulator value to int8, with optional ReLU applied
// before the clamp.
module int8_saturator
    import tpu_pkg::*;
#(
    parameter int unsigned ACC_W = tpu_pkg::ACC_W
) (
    input  logic signed [ACC_W-1:0] value,
    input  logic                    relu,
    output logic        [7:0]       result
);

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(INT8_MAX);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(INT8_MIN);

    always_comb begin
        result = value[7:0];
        if (relu && value[ACC_W-1]) begin
            result = 8'h00;
        end else if (value > SAT_HI) begin
            result = 8'h7F;
        end else if (value < SAT_LO) begin
            result = 8'h80;
        end
    end

endmodule

// File: rtl/result_streamer.sv
// Double-buffered drain stage: snapshots four accumulator results on capture
// and streams them as bytes under a valid/ready handshake.
module result_streamer
#(
    parameter int unsigned ACC_W = tpu_pkg::ACC_W,
    parameter int unsigned N_OUT = tpu_pkg::N_OUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   capture,
    input  logic [N_OUT*ACC_W-1:0] c_in,
    input  logic [1:0]             mode,
    input  logic                   flush,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    output logic                   out_last,
    output logic                   busy,
    output logic                   overrun
);

    import tpu_pkg::*;

    stream_state_t          state, state_next;
    logic [N_OUT*ACC_W-1:0] act_data, pend_data;
    out_mode_t              act_mode, pend_mode;
    logic                   pend_valid;
    logic [2:0]             idx, idx_next;
    logic                   overrun_q;

    logic xfer, frame_end;
    logic load_act_in, load_act_pend, load_pend, clr_pend, set_ovr, clr_ovr;

    assign xfer      = (state == ST_STREAM) && out_ready;
    assign frame_end = xfer && (idx == last_index(act_mode));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A frame's final transfer frees the active slot in the same cycle, so a
    // coincident capture is always accepted there rather than counted as overrun.
    always_comb begin
        state_next    = state;
        idx_next      = idx;
        load_act_in   = 1'b0;
        load_act_pend = 1'b0;
        load_pend     = 1'b0;
        clr_pend      = 1'b0;
        set_ovr       = 1'b0;
        clr_ovr       = 1'b0;
        if (flush) begin
            state_next = ST_IDLE;
            idx_next   = '0;
            clr_pend   = 1'b1;
            clr_ovr    = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (capture) begin
                        load_act_in = 1'b1;
                        idx_next    = '0;
                        state_next  = ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (frame_end) begin
                        idx_next = '0;
                        if (pend_valid) begin
                            load_act_pend = 1'b1;
                            if (capture) begin
                                load_pend = 1'b1;
                            end else begin
                                clr_pend = 1'b1;
                            end
                        end else if (capture) begin
                            load_act_in = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            idx_next = idx + 3'd1;
                        end
                        if (capture) begin
                            if (pend_valid) begin
                                set_ovr = 1'b1;
                            end else begin
                                load_pend = 1'b1;
                            end
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_data   <= '0;
            act_mode   <= MODE_RAW;
            pend_data  <= '0;
            pend_mode  <= MODE_RAW;
            pend_valid <= 1'b0;
            idx        <= '0;
            overrun_q  <= 1'b0;
        end else begin
            idx <= idx_next;
            if (load_act_in) begin
                act_data <= c_in;
                act_mode <= out_mode_t'(mode);
            end else if (load_act_pend) begin
                act_data <= pend_data;
                act_mode <= pend_mode;
            end
            if (load_pend) begin
                pend_data  <= c_in;
                pend_mode  <= out_mode_t'(mode);
                pend_valid <= 1'b1;
            end else if (clr_pend) begin
                pend_valid <= 1'b0;
            end
            if (clr_ovr) begin
                overrun_q <= 1'b0;
            end else if (set_ovr) begin
                overrun_q <= 1'b1;
            end
        end
    end

    logic [ACC_W-1:0] elems [N_OUT];
    logic [1:0]       elem_sel;
    logic [ACC_W-1:0] elem;
    logic [7:0]       sat_byte;
    logic             raw_mode;

    always_comb begin
        for (int unsigned i = 0; i < N_OUT; i++) begin
            elems[i] = act_data[i*ACC_W +: ACC_W];
        end
    end

    // Raw frames walk two bytes per element; int8 frames one byte per element.
    assign raw_mode = !is_int8_mode(act_mode);
    assign elem_sel = raw_mode ? idx[2:1] : idx[1:0];
    assign elem     = elems[elem_sel];

    int8_saturator #(
        .ACC_W(ACC_W)
    ) u_sat (
        .value  (elem),
        .relu   (act_mode == MODE_RELU8),
        .result (sat_byte)
    );

    assign out_data  = raw_mode ? (idx[0] ? elem[15:8] : elem[7:0]) : sat_byte;
    assign out_valid = (state == ST_STREAM);
    assign out_last  = out_valid && (idx == last_index(act_mode));
    assign busy      = (state == ST_STREAM) || pend_valid;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_result_streamer.sv
// Directed self-checking bench for result_streamer.
module tb_result_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        capture;
    logic [63:0] c_in;
    logic [1:0]  mode;
    logic        flush;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    result_streamer #(
        .ACC_W(16),
        .N_OUT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .c_in      (c_in),
        .mode      (mode),
        .flush     (flush),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; capture = 1'b0; flush = 1'b0; out_ready = 1'b1;
        c_in = '0; mode = 2'b00;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
            overrun !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset: valid=%b last=%b busy=%b ovr=%b data=%h want 0 0 0 0 00",
                     out_valid, out_last, busy, overrun, out_data);
        end
    endtask

    task automatic test_raw();
        logic [7:0] exp [8] = '{8'h34, 8'h12, 8'hFF, 8'h00, 8'h80, 8'hFF, 8'h01, 8'h00};
        c_in = {16'h0001, 16'hFF80, 16'h00FF, 16'h1234};
        mode = 2'b00; out_ready = 1'b1; capture = 1'b1;
        tick();
        capture = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== (i == 7) || busy !== 1'b1) begin
                errors++;
                $display("FAIL raw_byte%0d: valid=%b data=%h last=%b busy=%b want 1 %h %b 1",
                         i, out_valid, out_data, out_last, busy, exp[i], (i == 7));
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL raw_end: busy=%b valid=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_int8_modes();
        logic [7:0] exp [2][4] = '{'{8'h7F, 8'h80, 8'h05, 8'h85},
                                   '{8'h7F, 8'h00, 8'h05, 8'h00}};
        for (int m = 0; m < 2; m++) begin
            c_in = {16'hFF85, 16'h0005, 16'hFF00, 16'h0200};
            mode = (m == 0) ? 2'b01 : 2'b10;
            out_ready = 1'b1; capture = 1'b1;
            tick();
            capture = 1'b0;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp[m][i] || out_last !== (i == 3)) begin
                    errors++;
                    $display("FAIL int8_mode%0d_byte%0d: valid=%b data=%h last=%b want 1 %h %b",
                             m + 1, i, out_valid, out_data, out_last, exp[m][i], (i == 3));
                end
                tick();
            end
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL int8_mode%0d_end: valid=%b busy=%b want 0 0", m + 1, out_valid, busy);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [8] = '{8'h34, 8'h12, 8'hFF, 8'h00, 8'h80, 8'hFF, 8'h01, 8'h00};
        logic       pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int         n = 0;
        int         k = 0;
        c_in = {16'h0001, 16'hFF80, 16'h00FF, 16'h1234};
        mode = 2'b00; capture = 1'b1; out_ready = 1'b0;
        tick();
        capture = 1'b0;
        while (n < 8 && k < 60) begin
            out_ready = pat[k % 6];
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[n] || out_last !== (n == 7)) begin
                errors++;
                $display("FAIL bp_cycle%0d: valid=%b data=%h last=%b want 1 %h %b",
                         k, out_valid, out_data, out_last, exp[n], (n == 7));
            end
            if (out_valid && out_ready) n++;
            k++;
            tick();
        end
        out_ready = 1'b1;
        checks++;
        if (n !== 8 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: transfers=%0d valid=%b busy=%b want 8 0 0", n, out_valid, busy);
        end
    endtask

    task automatic test_double_buffer();
        logic [63:0] fa = {16'hFF85, 16'h0005, 16'hFF00, 16'h0200};
        logic [63:0] fb = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
        logic [63:0] fc = {16'h0055, 16'h0055, 16'h0055, 16'h0055};
        logic [63:0] fd = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        logic [7:0]  s1 [8]  = '{8'h7F, 8'h80, 8'h05, 8'h85, 8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0]  s2 [12] = '{8'h7F, 8'h80, 8'h05, 8'h85, 8'h11, 8'h22, 8'h33, 8'h44,
                                 8'h01, 8'h02, 8'h03, 8'h04};
        mode = 2'b01; out_ready = 1'b1;
        // A at 0, B while A byte1 shows, C while A byte2 shows (dropped)
        for (int k = 0; k <= 9; k++) begin
            if (k >= 1) begin
                checks++;
                if (out_valid !== (k <= 8) || (k <= 8 && out_data !== s1[k-1]) ||
                    overrun !== (k >= 4) || out_last !== (k == 4 || k == 8)) begin
                    errors++;
                    $display("FAIL dbuf_k%0d: valid=%b data=%h ovr=%b last=%b want %b %h %b %b",
                             k, out_valid, out_data, overrun, out_last, (k <= 8),
                             (k <= 8) ? s1[k-1] : 8'h00, (k >= 4), (k == 4 || k == 8));
                end
            end
            capture = (k == 0 || k == 2 || k == 3);
            c_in = (k == 0) ? fa : (k == 2) ? fb : fc;
            tick();
        end
        capture = 1'b0;
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL dbuf_idle: busy=%b ovr=%b want 0 1", busy, overrun);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL dbuf_flush_ovr: ovr=%b want 0", overrun);
        end
        // A at 0, B pending at 1, D coincides with A's final transfer at 4
        for (int k = 0; k <= 13; k++) begin
            if (k >= 1) begin
                checks++;
                if (out_valid !== (k <= 12) || (k <= 12 && out_data !== s2[k-1]) ||
                    overrun !== 1'b0 || out_last !== (k == 4 || k == 8 || k == 12)) begin
                    errors++;
                    $display("FAIL final_cap_k%0d: valid=%b data=%h ovr=%b last=%b want %b %h 0 %b",
                             k, out_valid, out_data, overrun, out_last, (k <= 12),
                             (k <= 12) ? s2[k-1] : 8'h00, (k == 4 || k == 8 || k == 12));
                end
            end
            capture = (k == 0 || k == 1 || k == 4);
            c_in = (k == 0) ? fa : (k == 1) ? fb : fd;
            tick();
        end
        capture = 1'b0;
    endtask

    task automatic test_abort(input logic use_rst);
        logic [63:0] fa = {16'h0001, 16'hFF80, 16'hBEEF, 16'h1234};
        mode = 2'b00; out_ready = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            if (k == 3) begin
                checks++;
                if (overrun !== 1'b1) begin
                    errors++;
                    $display("FAIL abort%0d_ovr_pre: ovr=%b want 1", use_rst, overrun);
                end
            end
            if (k == 4) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 8'hBE || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL abort%0d_byte3: valid=%b data=%h busy=%b want 1 be 1",
                             use_rst, out_valid, out_data, busy);
                end
            end
            capture = (k <= 2 || k == 4);
            c_in = fa;
            if (k == 4) begin
                if (use_rst) rst = 1'b1;
                else flush = 1'b1;
            end
            tick();
        end
        capture = 1'b0; rst = 1'b0; flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || out_last !== 1'b0 ||
            (use_rst && out_data !== 8'h00)) begin
            errors++;
            $display("FAIL abort%0d_after: valid=%b busy=%b ovr=%b last=%b data=%h want 0 0 0 0%s",
                     use_rst, out_valid, busy, overrun, out_last, out_data,
                     use_rst ? " 00" : "");
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort%0d_quiet%0d: valid=%b busy=%b want 0 0",
                         use_rst, k, out_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_int8_modes();
        test_backpressure();
        test_double_buffer();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_streamer.md
# result_streamer

Downstream drain stage for the 2x2 systolic array. On a capture pulse it snapshots the four 16-bit accumulator results (c00, c01, c10, c11), post-processes them according to a per-frame output mode, and streams them to the host pin interface as a byte stream under a valid/ready handshake. It is double-buffered, so a new result set can be captured while the previous one is still draining.

## Interface

Parameters:
- ACC_W, 16: accumulator width, signed two's complement.
- N_OUT, 4: result elements per frame.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- capture, input, 1: one-cycle pulse; latch c_in and mode.
- c_in, input, N_OUT*ACC_W: packed results. c00 is in [15:0], c01 in [31:16], c10 in [47:32], c11 in [63:48].
- mode, input, 2: output format, sampled only at capture.
  - 00 raw: 2 bytes per element.
  - 01 sat8: signed clamp to int8.
  - 10 relu8: clamp negatives to 0, then sat8.
  - 11 reserved: treated as raw.
- flush, input, 1: synchronous abort; empties both buffers.
- out_ready, input, 1: host accepts the current byte.
- out_data, output, 8: current byte.
- out_valid, output, 1: out_data is valid.
- out_last, output, 1: current byte is the final byte of its frame.
- busy, output, 1: the active buffer or the pending buffer is occupied.
- overrun, output, 1: sticky; a capture was dropped.

## Operation

**Buffers.** The block holds an active buffer and a pending buffer. Each buffer holds 4x16 data, a 2-bit mode and a valid bit.

**State machine.**
- IDLE: active buffer empty.
- STREAM: active buffer full.
- Byte index counter: 3 bits.
- Frame length: 8 bytes in raw mode, 4 bytes in sat8/relu8.

**Byte order.**
- Element order is c00, c01, c10, c11.
- Raw mode emits each element low byte first, then high byte.

**Arithmetic.**
- sat8: value > 127 gives 0x7F; value < -128 gives 0x80; otherwise the low byte.
- relu8: value < 0 gives 0x00; otherwise sat8.

**Transfers.**
- A transfer occurs on any cycle where out_valid && out_ready.
- The index increments on each transfer.
- out_last = out_valid && (index == frame length - 1).

**Capture rules.**
- Capture in IDLE: load the active buffer and go to STREAM.
- Capture in STREAM with pending empty: load pending.
- Capture in STREAM with pending full: drop the capture and set overrun. Exception: the same cycle is the final transfer of the frame; see the next bullet.
- Final transfer of a frame:
  - If pending is full, pending moves to active. A same-cycle capture goes into pending, and no overrun is set.
  - If pending is empty, a same-cycle capture goes directly into active.
  - Otherwise go to IDLE.
- The index resets to 0 whenever active is (re)loaded.

**Flush and reset.**
- flush clears both valid bits, the index and overrun, and returns to IDLE.
- flush has priority over capture in the same cycle.
- rst does the same as flush and also clears all data registers.

## Timing

- Reset values:
  - out_valid = 0, out_last = 0, busy = 0, overrun = 0.
  - out_data = 0x00.
  - State = IDLE, index = 0.
- Latency: capture at cycle N puts out_valid and byte 0 out at cycle N+1.
- out_data and out_valid are registered-stable. While out_valid && !out_ready, out_data, out_last and the index hold unchanged.
- With out_ready held high, a frame drains at 1 byte per cycle: 8 cycles (raw) or 4 cycles (sat8/relu8).
- Back-to-back frames: no bubble. Byte 0 of the next frame appears on the cycle after the previous frame's final transfer.
- out_valid never drops mid-frame except on flush or rst. Each takes effect the next cycle, and any in-flight byte is discarded.
- busy is high from the cycle after the accepted capture until the cycle after the final transfer with no pending frame.
- A mode change between captures affects only subsequent frames.

## Structure

- Shared package tpu_pkg holds:
  - The out-mode enum (MODE_RAW, MODE_SAT8, MODE_RELU8).
  - ACC_W.
  - INT8_MAX and INT8_MIN.
  - The frame-length constants (8 and 4).
- One combinational sub-module, int8_saturator: ACC_W signed input plus a relu enable, 8-bit output. The byte mux instantiates it once, on the currently selected element.
- Everything else, including the buffers, FSM, index and handshake, lives in result_streamer.

## Test plan

- **Raw mode, ready high.**
  - Stimulus: c00=0x1234, c01=0x00FF, c10=0xFF80, c11=0x0001, mode 00.
  - Response: bytes 34 12 FF 00 80 FF 01 00 on cycles N+1..N+8; out_last only with 00 at N+8; busy falls at N+9.
- **sat8 mode.**
  - Stimulus: c00=0x0200, c01=0xFF00, c10=0x0005, c11=0xFF85.
  - Response: bytes 7F 80 05 85.
- **relu8 mode.**
  - Stimulus: the same values as sat8.
  - Response: bytes 7F 00 05 00.
- **Backpressure.**
  - Stimulus: raw frame with out_ready pattern 1,0,0,1,0,1....
  - Response: out_data holds across stalls; the byte sequence is identical to the ready-high case; exactly 8 transfers.
- **Double buffering and overrun.**
  - Stimulus:
    - Capture frame A (sat8).
    - Capture frame B at the 2nd byte of A.
    - Capture frame C at the 3rd byte of A.
  - Response: A then B stream with no gap cycle; C is dropped; overrun rises the cycle after C's capture and stays high.
  - Second stimulus: a capture coincident with A's final transfer while pending is full.
  - Response: no overrun.
- **Flush and reset mid-stream.**
  - Stimulus: flush at byte 3 of a raw frame, with a pending frame and a same-cycle capture.
  - Response: next cycle out_valid=0, busy=0, overrun=0; nothing is emitted afterward.
  - Stimulus: repeat with rst.
  - Response: identical, plus out_data=0x00.
